// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Data requests win by default; a streak counter bounds how long a pending fetch can wait.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                halt,
    output logic                idle,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [ADDR_W-1:0]   i_req_addr,
    output logic                i_rsp_valid,
    output logic [DATA_W-1:0]   i_rsp_data,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic                d_req_we,
    input  logic [DATA_W/8-1:0] d_req_wstrb,
    input  logic [DATA_W-1:0]   d_req_wdata,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_data,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int SW = $clog2(MAX_STREAK + 1);

    typedef enum logic [1:0] {
        OWN_NONE    = 2'd0,
        OWN_I       = 2'd1,
        OWN_D_LOAD  = 2'd2,
        OWN_D_STORE = 2'd3
    } owner_t;

    owner_t        owner, owner_next;
    logic [SW-1:0] streak, streak_next;
    logic          at_limit;
    logic          grant_i, grant_d;

    // Handshake: a request transfers in the cycle where valid and ready are both high;
    // ready is a same-cycle function of valid, and the response is a one-cycle pulse
    // exactly one cycle later with no backpressure.
    always_comb begin
        at_limit = (streak == SW'(MAX_STREAK));
        grant_d  = 1'b0;
        grant_i  = 1'b0;
        if (!rst && !halt) begin
            if (d_req_valid && !(i_req_valid && at_limit)) begin
                grant_d = 1'b1;
            end else if (i_req_valid) begin
                grant_i = 1'b1;
            end
        end
    end

    always_comb begin
        owner_next  = OWN_NONE;
        streak_next = streak;
        if (grant_i) begin
            owner_next = OWN_I;
        end else if (grant_d) begin
            owner_next = d_req_we ? OWN_D_STORE : OWN_D_LOAD;
        end
        // Streak only measures data grants that actually made a fetch wait.
        if (!i_req_valid || grant_i) begin
            streak_next = '0;
        end else if (grant_d && !at_limit) begin
            streak_next = streak + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner  <= OWN_NONE;
            streak <= '0;
        end else begin
            owner  <= owner_next;
            streak <= streak_next;
        end
    end

    always_comb begin
        i_req_ready = grant_i;
        d_req_ready = grant_d;
        mem_en      = grant_i | grant_d;
        mem_addr    = grant_d ? d_req_addr : i_req_addr;
        mem_we      = grant_d & d_req_we;
        mem_wstrb   = grant_d ? d_req_wstrb : '0;
        mem_wdata   = d_req_wdata;
    end

    always_comb begin
        i_rsp_valid = (owner == OWN_I);
        i_rsp_data  = (owner == OWN_I) ? mem_rdata : '0;
        d_rsp_valid = (owner == OWN_D_LOAD) || (owner == OWN_D_STORE);
        d_rsp_data  = (owner == OWN_D_LOAD) ? mem_rdata : '0;
        idle        = !rst && halt && (owner == OWN_NONE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed row tables per scenario plus a
// randomized run, with a response scoreboard and a behavioural memory.
module tb_mem_port_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int MAX_STREAK = 4;
    localparam int RW         = 2 + 2 * DW;
    localparam int NROW       = 48;

    logic          clk = 1'b0;
    logic          rst;
    logic          halt;
    logic          idle;
    logic          i_req_valid, i_req_ready;
    logic [AW-1:0] i_req_addr;
    logic          i_rsp_valid;
    logic [DW-1:0] i_rsp_data;
    logic          d_req_valid, d_req_ready;
    logic [AW-1:0] d_req_addr;
    logic          d_req_we;
    logic [3:0]    d_req_wstrb;
    logic [DW-1:0] d_req_wdata;
    logic          d_rsp_valid;
    logic [DW-1:0] d_rsp_data;
    logic          mem_en, mem_we;
    logic [3:0]    mem_wstrb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [RW-1:0] exp_q[$];

    logic        t_rst[NROW], t_iv[NROW], t_dv[NROW], t_we[NROW], t_h[NROW], t_idle[NROW];
    logic [31:0] t_ia[NROW], t_da[NROW], t_wd[NROW];
    logic [3:0]  t_ws[NROW];
    logic [1:0]  t_g[NROW];

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MAX_STREAK)) dut (
        .clk(clk), .rst(rst), .halt(halt), .idle(idle),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wstrb(d_req_wstrb), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    // Fixed memory contents: a known word at 0, a hash elsewhere.
    function automatic logic [31:0] rd(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk)
        mem_rdata <= (mem_en === 1'b1 && mem_we === 1'b0) ? rd(mem_addr) : 32'hBAD0_BAD0;

    // Driver tasks
    task automatic set_row(input int k, input logic iv, input logic [31:0] ia, input logic dv,
                           input logic we, input logic [3:0] ws, input logic [31:0] da,
                           input logic [31:0] wd, input logic h, input logic [1:0] g,
                           input logic idl);
        t_rst[k] = 1'b0; t_iv[k] = iv; t_ia[k] = ia; t_dv[k] = dv; t_we[k] = we;
        t_ws[k] = ws; t_da[k] = da; t_wd[k] = wd; t_h[k] = h; t_g[k] = g; t_idle[k] = idl;
    endtask

    task automatic set_rst_row(input int k, input logic iv, input logic dv);
        set_row(k, iv, 32'h10, dv, 1'b0, 4'h0, 32'h4100, 32'h0, 1'b0, 2'd0, 1'b0);
        t_rst[k] = 1'b1;
    endtask

    task automatic drive_row(input int k);
        rst         = t_rst[k];
        halt        = t_h[k];
        i_req_valid = t_iv[k];
        i_req_addr  = t_ia[k];
        d_req_valid = t_dv[k];
        d_req_addr  = t_da[k];
        d_req_we    = t_we[k];
        d_req_wstrb = t_ws[k];
        d_req_wdata = t_wd[k];
    endtask

    // Scoreboard helpers
    function automatic logic [34:0] grant_exp(input int k);
        logic [31:0] ea;
        ea = (t_g[k] == 2'd1) ? t_ia[k] : (t_g[k] == 2'd2) ? t_da[k] : 32'h0;
        return {t_g[k] == 2'd1, t_g[k] == 2'd2, t_g[k] != 2'd0, ea};
    endfunction

    function automatic logic [34:0] obs_grant();
        return {i_req_ready, d_req_ready, mem_en, (mem_en === 1'b1) ? mem_addr : 32'h0};
    endfunction

    function automatic logic [RW-1:0] rsp_exp(input int k);
        if (t_g[k] == 2'd1) return {2'b10, rd(t_ia[k]), 32'h0};
        if (t_g[k] == 2'd2) return t_we[k] ? {2'b01, 64'h0} : {2'b01, 32'h0, rd(t_da[k])};
        return '0;
    endfunction

    function automatic logic [RW-1:0] obs_rsp();
        return {i_rsp_valid, d_rsp_valid, i_rsp_data, d_rsp_data};
    endfunction

    function automatic logic [RW-1:0] pop_exp();
        if (exp_q.size() == 0) return '0;
        return exp_q.pop_front();
    endfunction

    function automatic logic [RW-1:0] flush_exp();
        exp_q.delete();
        return '0;
    endfunction

    task automatic test_reset();
        rst = 1'b1; halt = 1'b1;
        i_req_valid = 1'b1; i_req_addr = 32'h40;
        d_req_valid = 1'b1; d_req_addr = 32'h80;
        d_req_we = 1'b0; d_req_wstrb = 4'h0; d_req_wdata = 32'h0;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({i_req_ready, d_req_ready, mem_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset grant: got %b want 000", {i_req_ready, d_req_ready, mem_en});
        end
        n_cmp++;
        if (obs_rsp() !== '0) begin
            n_fail++;
            $display("FAIL reset rsp: got %h want 0", obs_rsp());
        end
        n_cmp++;
        if (idle !== 1'b0) begin
            n_fail++;
            $display("FAIL reset idle: got %b want 0", idle);
        end
        @(negedge clk);
        rst = 1'b0; halt = 1'b0; i_req_valid = 1'b0; d_req_valid = 1'b0;
        #1;
        n_cmp++;
        if ({mem_en, idle, i_rsp_valid, d_rsp_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset release: got %b want 0000", {mem_en, idle, i_rsp_valid, d_rsp_valid});
        end
        exp_q.delete();
        exp_q.push_back('0);
    endtask

    task automatic test_fetch_only();
        logic [RW-1:0] e;
        set_row(0, 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd1, 1'b0);
        set_row(1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        set_row(2, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_row(k);
            #1;
            n_cmp++;
            if (obs_grant() !== grant_exp(k)) begin
                n_fail++;
                $display("FAIL fetch_only grant row %0d: got %h want %h", k, obs_grant(), grant_exp(k));
            end
            e = t_rst[k] ? flush_exp() : pop_exp();
            n_cmp++;
            if (obs_rsp() !== e) begin
                n_fail++;
                $display("FAIL fetch_only rsp row %0d: got %h want %h", k, obs_rsp(), e);
            end
            exp_q.push_back(rsp_exp(k));
        end
    endtask

    task automatic test_conflict();
        logic [RW-1:0] e;
        set_row(0, 1'b1, 32'h44, 1'b1, 1'b0, 4'h0, 32'h2000, 32'h0, 1'b0, 2'd2, 1'b0);
        set_row(1, 1'b1, 32'h44, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd1, 1'b0);
        set_row(2, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        set_row(3, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_row(k);
            #1;
            n_cmp++;
            if (obs_grant() !== grant_exp(k)) begin
                n_fail++;
                $display("FAIL conflict grant row %0d: got %h want %h", k, obs_grant(), grant_exp(k));
            end
            e = t_rst[k] ? flush_exp() : pop_exp();
            n_cmp++;
            if (obs_rsp() !== e) begin
                n_fail++;
                $display("FAIL conflict rsp row %0d: got %h want %h", k, obs_rsp(), e);
            end
            exp_q.push_back(rsp_exp(k));
        end
    endtask

    task automatic test_starvation();
        logic [RW-1:0] e;
        for (int k = 0; k < 6; k++)
            set_row(k, 1'b1, 32'h100, 1'b1, 1'b0, 4'h0, 32'h3000 + 32'(4 * k), 32'h0, 1'b0,
                    (k == 4) ? 2'd1 : 2'd2, 1'b0);
        set_row(6, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            drive_row(k);
            #1;
            n_cmp++;
            if (obs_grant() !== grant_exp(k)) begin
                n_fail++;
                $display("FAIL starvation grant row %0d: got %h want %h", k, obs_grant(), grant_exp(k));
            end
            e = t_rst[k] ? flush_exp() : pop_exp();
            n_cmp++;
            if (obs_rsp() !== e) begin
                n_fail++;
                $display("FAIL starvation rsp row %0d: got %h want %h", k, obs_rsp(), e);
            end
            exp_q.push_back(rsp_exp(k));
        end
    endtask

    task automatic test_store();
        logic [RW-1:0] e;
        logic [36:0]   mexp;
        set_row(0, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h1000, 32'hDEAD_BEEF, 1'b0, 2'd2, 1'b0);
        set_row(1, 1'b0, 32'h0, 1'b1, 1'b0, 4'h3, 32'h1004, 32'h0, 1'b0, 2'd2, 1'b0);
        set_row(2, 1'b1, 32'h200, 1'b1, 1'b1, 4'h5, 32'h1008, 32'h1234_5678, 1'b0, 2'd2, 1'b0);
        set_row(3, 1'b1, 32'h200, 1'b0, 1'b1, 4'hF, 32'h0, 32'h0, 1'b0, 2'd1, 1'b0);
        set_row(4, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive_row(k);
            #1;
            n_cmp++;
            if (obs_grant() !== grant_exp(k)) begin
                n_fail++;
                $display("FAIL store grant row %0d: got %h want %h", k, obs_grant(), grant_exp(k));
            end
            if (t_g[k] != 2'd0) begin
                mexp = {t_g[k] == 2'd2 && t_we[k], (t_g[k] == 2'd2) ? t_ws[k] : 4'h0,
                        (t_g[k] == 2'd2 && t_we[k]) ? t_wd[k] : 32'h0};
                n_cmp++;
                if ({mem_we, mem_wstrb, mem_we ? mem_wdata : 32'h0} !== mexp) begin
                    n_fail++;
                    $display("FAIL store mem row %0d: got %h want %h", k,
                             {mem_we, mem_wstrb, mem_we ? mem_wdata : 32'h0}, mexp);
                end
            end
            e = t_rst[k] ? flush_exp() : pop_exp();
            n_cmp++;
            if (obs_rsp() !== e) begin
                n_fail++;
                $display("FAIL store rsp row %0d: got %h want %h", k, obs_rsp(), e);
            end
            exp_q.push_back(rsp_exp(k));
        end
    endtask

    task automatic test_halt();
        logic [RW-1:0] e;
        set_row(0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h2004, 32'h0, 1'b0, 2'd2, 1'b0);
        set_row(1, 1'b1, 32'h48, 1'b1, 1'b0, 4'h0, 32'h2008, 32'h0, 1'b1, 2'd0, 1'b0);
        set_row(2, 1'b1, 32'h48, 1'b1, 1'b0, 4'h0, 32'h2008, 32'h0, 1'b1, 2'd0, 1'b1);
        set_row(3, 1'b1, 32'h48, 1'b1, 1'b0, 4'h0, 32'h2008, 32'h0, 1'b1, 2'd0, 1'b1);
        set_row(4, 1'b1, 32'h48, 1'b1, 1'b0, 4'h0, 32'h2008, 32'h0, 1'b0, 2'd2, 1'b0);
        set_row(5, 1'b1, 32'h48, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd1, 1'b0);
        set_row(6, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        // Streak of four, then halt, then resume: the saturated streak must survive halt.
        for (int k = 7; k < 11; k++)
            set_row(k, 1'b1, 32'h4C, 1'b1, 1'b0, 4'h0, 32'h2100 + 32'(4 * k), 32'h0, 1'b0, 2'd2, 1'b0);
        set_row(11, 1'b1, 32'h4C, 1'b1, 1'b0, 4'h0, 32'h2200, 32'h0, 1'b1, 2'd0, 1'b0);
        set_row(12, 1'b1, 32'h4C, 1'b1, 1'b0, 4'h0, 32'h2200, 32'h0, 1'b1, 2'd0, 1'b1);
        set_row(13, 1'b1, 32'h4C, 1'b1, 1'b0, 4'h0, 32'h2200, 32'h0, 1'b0, 2'd1, 1'b0);
        set_row(14, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            drive_row(k);
            #1;
            n_cmp++;
            if (obs_grant() !== grant_exp(k)) begin
                n_fail++;
                $display("FAIL halt grant row %0d: got %h want %h", k, obs_grant(), grant_exp(k));
            end
            e = t_rst[k] ? flush_exp() : pop_exp();
            n_cmp++;
            if (obs_rsp() !== e) begin
                n_fail++;
                $display("FAIL halt rsp row %0d: got %h want %h", k, obs_rsp(), e);
            end
            n_cmp++;
            if (idle !== t_idle[k]) begin
                n_fail++;
                $display("FAIL halt idle row %0d: got %b want %b", k, idle, t_idle[k]);
            end
            exp_q.push_back(rsp_exp(k));
        end
    endtask

    task automatic test_reset_midop();
        logic [RW-1:0] e;
        set_row(0, 1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd1, 1'b0);
        set_rst_row(1, 1'b0, 1'b0);
        set_row(2, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        set_row(3, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        set_row(4, 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd1, 1'b0);
        set_row(5, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        for (int k = 6; k < 9; k++)
            set_row(k, 1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h4000 + 32'(4 * k), 32'h0, 1'b0, 2'd2, 1'b0);
        set_rst_row(9, 1'b1, 1'b1);
        for (int k = 10; k < 15; k++)
            set_row(k, 1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h4000 + 32'(4 * k), 32'h0, 1'b0,
                    (k == 14) ? 2'd1 : 2'd2, 1'b0);
        set_row(15, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            drive_row(k);
            #1;
            n_cmp++;
            if (obs_grant() !== grant_exp(k)) begin
                n_fail++;
                $display("FAIL reset_midop grant row %0d: got %h want %h", k, obs_grant(), grant_exp(k));
            end
            e = t_rst[k] ? flush_exp() : pop_exp();
            n_cmp++;
            if (obs_rsp() !== e) begin
                n_fail++;
                $display("FAIL reset_midop rsp row %0d: got %h want %h", k, obs_rsp(), e);
            end
            exp_q.push_back(rsp_exp(k));
        end
    endtask

    task automatic test_random();
        logic [RW-1:0] e;
        int            st;
        logic [1:0]    g, prev_g;
        logic          iv, dv, h;
        st = 0;
        prev_g = 2'd0;
        for (int k = 0; k < 40; k++) begin
            iv = 1'($urandom_range(0, 1));
            dv = 1'($urandom_range(0, 1));
            h  = ($urandom_range(0, 4) == 0);
            if (h)                                  g = 2'd0;
            else if (dv && !(iv && st == MAX_STREAK)) g = 2'd2;
            else if (iv)                            g = 2'd1;
            else                                    g = 2'd0;
            set_row(k, iv, {14'h0, 16'($urandom_range(0, 16'hFFFF)), 2'b00}, dv,
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    {14'h1, 16'($urandom_range(0, 16'hFFFF)), 2'b00}, $urandom(), h, g,
                    h && (prev_g == 2'd0));
            if (!iv || g == 2'd1)              st = 0;
            else if (g == 2'd2 && st < MAX_STREAK) st = st + 1;
            prev_g = g;
        end
        set_row(40, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 41; k++) begin
            @(negedge clk);
            drive_row(k);
            #1;
            n_cmp++;
            if (obs_grant() !== grant_exp(k)) begin
                n_fail++;
                $display("FAIL random grant row %0d: got %h want %h", k, obs_grant(), grant_exp(k));
            end
            e = t_rst[k] ? flush_exp() : pop_exp();
            n_cmp++;
            if (obs_rsp() !== e) begin
                n_fail++;
                $display("FAIL random rsp row %0d: got %h want %h", k, obs_rsp(), e);
            end
            n_cmp++;
            if (idle !== t_idle[k]) begin
                n_fail++;
                $display("FAIL random idle row %0d: got %b want %b", k, idle, t_idle[k]);
            end
            exp_q.push_back(rsp_exp(k));
        end
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_conflict();
        test_starvation();
        test_store();
        test_halt();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the core's single-port unified memory between the instruction-fetch requester and the load/store requester. Each requester uses a valid/ready request channel and a fixed one-cycle response. Data accesses win by default; a streak counter prevents fetch starvation. A halt input lets the simulation harness quiesce the port so it can inspect memory and register state at a known point, such as pass/fail detection.

Parameters:
ADDR_W, 32, byte address width passed to memory
DATA_W, 32, data word width
MAX_STREAK, 4, max consecutive data grants while a fetch is pending (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
halt  in  1  stop accepting new requests
idle  out  1  halted and no response outstanding
i_req_valid  in  1  fetch request valid
i_req_ready  out  1  fetch request accepted this cycle
i_req_addr  in  ADDR_W  fetch byte address
i_rsp_valid  out  1  fetch read data valid
i_rsp_data  out  DATA_W  fetched word
d_req_valid  in  1  data request valid
d_req_ready  out  1  data request accepted this cycle
d_req_addr  in  ADDR_W  data byte address
d_req_we  in  1  1=store, 0=load
d_req_wstrb  in  DATA_W/8  store byte enables
d_req_wdata  in  DATA_W  store data
d_rsp_valid  out  1  data response valid (load data or store ack)
d_rsp_data  out  DATA_W  load data; 0 for store ack
mem_en  out  1  memory access this cycle
mem_we  out  1  memory write
mem_wstrb  out  DATA_W/8  memory byte enables
mem_addr  out  ADDR_W  memory byte address, unmodified
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en

Behaviour:
- Clocking: one clock domain. The asynchronous active-high reset clears the streak counter, the response-owner register and all rsp_valid outputs.
- Reset values: i_rsp_valid=0, d_rsp_valid=0, both rsp_data=0, idle=0. mem_en=0 while rst is high.
- Grant (combinational, same cycle):
  - If halt=1, no grant.
  - Else if d_req_valid and not (i_req_valid and streak==MAX_STREAK), grant data.
  - Else if i_req_valid, grant fetch.
  - At most one ready is high per cycle. A ready is never high without its valid.
- Memory drive on grant:
  - mem_en=1; mem_addr=granted addr.
  - Data grant: mem_we=d_req_we, mem_wstrb=d_req_wstrb, mem_wdata=d_req_wdata.
  - Fetch grant: mem_we=0, mem_wstrb=0.
  - With no grant, mem_en=0 and the other mem_* outputs are don't-care.
- Response owner: registered on grant as NONE, I, D_LOAD or D_STORE.
- Response, exactly one cycle after acceptance:
  - I: i_rsp_valid=1, i_rsp_data=mem_rdata.
  - D_LOAD: d_rsp_valid=1, d_rsp_data=mem_rdata.
  - D_STORE: d_rsp_valid=1, d_rsp_data=0.
  - rsp_valid is a single-cycle pulse with no backpressure; requesters must sink it.
- Throughput: one accepted request per cycle, back-to-back allowed. The response for request N coincides with the grant for N+1.
- Streak counter:
  - +1 on each data grant made while i_req_valid=1; saturates at MAX_STREAK.
  - Cleared on a fetch grant, or in any cycle with i_req_valid=0.
- Halt:
  - Takes effect in the same cycle: no grant.
  - A response already owed is still delivered the next cycle.
  - idle = halt and owner==NONE (registered owner).
  - Deasserting halt resumes arbitration in the same cycle with the streak preserved.
- Reset mid-operation: an owed response is dropped; no rsp_valid pulse after reset release until a new grant.
- Requester stability: requesters hold valid and payload stable until ready. The arbiter does not check this.

Test Plan:
- Fetch only: i_req_valid=1, addr 0x0; mem_rdata=0x00000093 next cycle -> i_req_ready=1 in cycle 0, mem_en=1, mem_addr=0x0; i_rsp_valid=1 with 0x00000093 in cycle 1, 0 in cycle 2.
- Conflict: both valid in cycle 0, d load at 0x2000, i at 0x44 -> cycle 0: d_req_ready=1, i_req_ready=0, mem_addr=0x2000. Cycle 1: i granted, mem_addr=0x44, d_rsp_valid=1.
- Starvation guard (MAX_STREAK=4): d_req_valid and i_req_valid held 6 cycles -> grant sequence D,D,D,D,I,D.
- Store: d_we=1, wstrb=0xF, addr=0x1000, wdata=0xDEADBEEF -> same cycle mem_we=1, mem_wstrb=0xF, mem_wdata=0xDEADBEEF; next cycle d_rsp_valid=1, d_rsp_data=0.
- Halt: load accepted in cycle 0, halt=1 in cycle 1 with both valid -> no ready in cycle 1, d_rsp_valid=1 in cycle 1, idle=1 from cycle 2. halt=0 in cycle 4 -> grant in cycle 4.
- Reset mid-op: rst pulsed in the cycle after a fetch grant -> i_rsp_valid=0 immediately, no later pulse, streak=0; first post-reset grant behaves as in the fetch-only scenario.
